// File: rtl/bitrev_seq.sv
// Sequencer for a bit-reversal stage: fills one block before producing output,
// applies downstream backpressure to the stage clock enable, flushes the last
// block with zero data at end of stream, then resets the bitreverse memory.
module bitrev_seq #(
  parameter int unsigned LGSIZE = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in_valid,
  input  logic i_in_last,
  input  logic i_in_eos,
  output logic o_in_ready,
  output logic o_out_valid,
  input  logic i_out_ready,
  output logic o_out_last,
  output logic o_ce,
  output logic o_zero,
  output logic o_br_reset,
  input  logic i_br_sync,
  output logic o_frame_err,
  output logic o_sync_err,
  output logic o_busy
);

  localparam int unsigned CW = LGSIZE - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << CW) - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, in_cnt_nxt;
  logic [CW-1:0] out_cnt, out_cnt_nxt;
  logic          out_valid_nxt;
  logic          frame_err_nxt;
  logic          sync_err_nxt;
  logic          ce_ok;
  logic          in_acc;
  logic          out_acc;
  logic          in_at_max;
  logic          drain_exit;

  // Handshake, clock-enable decode and next-state logic
  always_comb begin
    o_in_ready    = 1'b0;
    o_ce          = 1'b0;
    o_zero        = 1'b0;
    drain_exit    = 1'b0;
    state_nxt     = state;
    ce_ok         = !o_out_valid | i_out_ready;
    in_at_max     = (in_cnt == CNT_MAX);

    unique case (state)
      FILL, RUN: begin
        o_in_ready = ce_ok;
        o_ce       = i_in_valid & ce_ok;
      end
      FLUSH: begin
        o_ce   = ce_ok;
        o_zero = 1'b1;
      end
      DRAIN: begin
        drain_exit = !o_out_valid;
      end
      default: begin
        o_in_ready = 1'b0;
      end
    endcase

    in_acc  = i_in_valid & o_in_ready;
    out_acc = o_out_valid & i_out_ready;

    in_cnt_nxt  = o_ce ? (in_cnt + CNT_ONE) : in_cnt;
    out_cnt_nxt = out_acc ? (out_cnt + CNT_ONE) : out_cnt;

    unique case (state)
      FILL: begin
        if (o_ce && in_at_max)
          state_nxt = (i_in_last && i_in_eos) ? FLUSH : RUN;
      end
      RUN: begin
        if (o_ce && in_at_max && i_in_last && i_in_eos)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        if (o_ce && in_at_max)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_exit) begin
          state_nxt   = FILL;
          in_cnt_nxt  = '0;
          out_cnt_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase

    // Only beats clocked after the block is full produce output
    if (o_ce && (state == RUN || state == FLUSH))
      out_valid_nxt = 1'b1;
    else if (i_out_ready)
      out_valid_nxt = 1'b0;
    else
      out_valid_nxt = o_out_valid;

    frame_err_nxt = in_acc & ((i_in_last != in_at_max) | (i_in_eos & !i_in_last));
    sync_err_nxt  = out_acc & (i_br_sync != (out_cnt == '0));

    o_br_reset = i_reset | drain_exit;
    o_out_last = o_out_valid & (out_cnt == CNT_MAX);
    o_busy     = (state != FILL) | (in_cnt != '0);
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= FILL;
      in_cnt      <= '0;
      out_cnt     <= '0;
      o_out_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_sync_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_cnt      <= in_cnt_nxt;
      out_cnt     <= out_cnt_nxt;
      o_out_valid <= out_valid_nxt;
      o_frame_err <= frame_err_nxt;
      o_sync_err  <= sync_err_nxt;
    end
  end

endmodule

// File: tb/tb_bitrev_seq.sv
// Directed bench for bitrev_seq at LGSIZE=5 (16-beat blocks).
module tb_bitrev_seq;

  logic i_clk = 1'b0;
  logic i_reset, i_in_valid, i_in_last, i_in_eos, i_out_ready, i_br_sync;
  logic o_in_ready, o_out_valid, o_out_last, o_ce, o_zero, o_br_reset;
  logic o_frame_err, o_sync_err, o_busy;

  bitrev_seq #(.LGSIZE(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_in_valid(i_in_valid),
    .i_in_last(i_in_last), .i_in_eos(i_in_eos), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_last(o_out_last), .o_ce(o_ce), .o_zero(o_zero),
    .o_br_reset(o_br_reset), .i_br_sync(i_br_sync),
    .o_frame_err(o_frame_err), .o_sync_err(o_sync_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Event tallies gathered once per cycle
  int n_ce, n_zero, n_in, n_out, n_last, n_valid, n_ferr, n_serr, n_brst, n_brbad;
  int first_last, last_idx, acc_mod;
  int s_ce, s_in_ready, s_valid, s_last;
  logic sync_flip;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_ce = 0; n_zero = 0; n_in = 0; n_out = 0; n_last = 0; n_valid = 0;
    n_ferr = 0; n_serr = 0; n_brst = 0; n_brbad = 0;
    first_last = 0; last_idx = 0;
  endtask

  // One clock: called at a negedge with inputs set; samples mid-cycle
  task automatic tick();
    i_br_sync = (acc_mod == 0) ^ sync_flip;
    #1;
    s_ce = int'(o_ce); s_in_ready = int'(o_in_ready);
    s_valid = int'(o_out_valid); s_last = int'(o_out_last);
    if (o_ce) n_ce++;
    if (o_ce && o_zero) n_zero++;
    if (i_in_valid && o_in_ready) n_in++;
    if (o_out_valid) n_valid++;
    if (o_frame_err) n_ferr++;
    if (o_sync_err) n_serr++;
    if (o_br_reset) n_brst++;
    if (!i_reset && o_br_reset && (o_ce || o_in_ready)) n_brbad++;
    if (o_out_valid && i_out_ready) begin
      n_out++;
      if (o_out_last) begin
        n_last++;
        last_idx = n_out;
        if (n_last == 1) first_last = n_out;
      end
    end
    if (i_reset) acc_mod = 0;
    else if (o_out_valid && i_out_ready) acc_mod = (acc_mod + 1) % 16;
    @(negedge i_clk);
  endtask

  task automatic beat(input logic last, input logic eos, input logic rdy);
    i_in_valid = 1'b1; i_in_last = last; i_in_eos = eos; i_out_ready = rdy;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_in_valid = 1'b0; i_in_last = 1'b0; i_in_eos = 1'b0; i_out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    clr();
  endtask

  initial begin
    i_reset = 1'b1; i_in_valid = 1'b0; i_in_last = 1'b0; i_in_eos = 1'b0;
    i_out_ready = 1'b1; i_br_sync = 1'b0; sync_flip = 1'b0; acc_mod = 0;
    clr();
    @(negedge i_clk);

    // Reset state
    idle(2);
    #1;
    chk("rst_br_reset", int'(o_br_reset), 1);
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_in_ready", int'(o_in_ready), 1);
    chk("rst_ce", int'(o_ce), 0);
    chk("rst_errs", int'(o_frame_err) + int'(o_sync_err), 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    clr();

    // First block fills silently; beat 17 yields first output
    for (int k = 0; k < 16; k++) beat(k == 15, 1'b0, 1'b1);
    chk("fill_no_valid", n_valid, 0);
    chk("fill_busy", int'(o_busy), 1);
    beat(1'b0, 1'b0, 1'b1);
    chk("first_out_valid", int'(o_out_valid), 1);
    chk("first_out_last", int'(o_out_last), 0);
    beat(1'b0, 1'b0, 1'b1);
    chk("sync_ok_no_err", int'(o_sync_err), 0);
    sync_flip = 1'b1;
    beat(1'b0, 1'b0, 1'b1);
    sync_flip = 1'b0;
    chk("sync_bad_pulse", int'(o_sync_err), 1);
    beat(1'b0, 1'b0, 1'b1);
    chk("sync_pulse_end", int'(o_sync_err), 0);

    // Continuous 48 beats, last on every 16th
    do_reset();
    for (int k = 0; k < 48; k++) beat((k % 16) == 15, 1'b0, 1'b1);
    idle(3);
    chk("cont_outputs", n_out, 32);
    chk("cont_lasts", n_last, 2);
    chk("cont_first_last", first_last, 16);
    chk("cont_second_last", last_idx, 32);
    chk("cont_ferr", n_ferr, 0);
    chk("cont_serr", n_serr, 0);

    // Downstream stall for 5 cycles in RUN
    do_reset();
    for (int k = 0; k < 20; k++) beat((k % 16) == 15, 1'b0, 1'b1);
    begin
      int stall_en = 0;
      int stall_valid = 0;
      int stall_last = 0;
      for (int k = 0; k < 5; k++) begin
        beat(1'b0, 1'b0, 1'b0);
        stall_en += s_ce + s_in_ready;
        stall_valid += s_valid;
        stall_last += s_last;
      end
      chk("stall_ce_ready", stall_en, 0);
      chk("stall_valid_held", stall_valid, 5);
      chk("stall_last_held", stall_last, 0);
    end
    chk("stall_in_accepted", n_in, 20);
    for (int k = 20; k < 32; k++) beat((k % 16) == 15, 1'b0, 1'b1);
    idle(2);
    chk("stall_total_in", n_in, 32);
    chk("stall_total_out", n_out, 16);
    chk("stall_lasts", n_last, 1);

    // Early last on beat 10
    do_reset();
    for (int k = 0; k < 10; k++) beat(k == 9, 1'b0, 1'b1);
    chk("ferr_pulse", int'(o_frame_err), 1);
    beat(1'b0, 1'b0, 1'b1);
    chk("ferr_pulse_end", int'(o_frame_err), 0);
    for (int k = 11; k < 16; k++) beat(k == 15, 1'b0, 1'b1);
    chk("ferr_no_valid", int'(o_out_valid), 0);
    beat(1'b0, 1'b0, 1'b1);
    chk("ferr_block_done", int'(o_out_valid), 1);
    chk("ferr_count", n_ferr, 1);

    // End of stream on beat 32: flush, drain, memory reset
    do_reset();
    for (int k = 0; k < 32; k++) beat((k % 16) == 15, k == 31, 1'b1);
    chk("eos_busy", int'(o_busy), 1);
    chk("eos_in_ready", int'(o_in_ready), 0);
    chk("eos_zero", int'(o_zero), 1);
    n_ce = 0;
    idle(20);
    chk("flush_ce", n_ce, 16);
    chk("flush_zero_ce", n_zero, 16);
    chk("flush_outputs", n_out, 32);
    chk("flush_lasts", n_last, 2);
    chk("drain_br_reset", n_brst, 1);
    chk("drain_br_quiet", n_brbad, 0);
    chk("drain_busy", int'(o_busy), 0);
    chk("drain_in_ready", int'(o_in_ready), 1);
    chk("eos_ferr", n_ferr, 0);
    chk("eos_serr", n_serr, 0);

    // Reset mid-block in RUN with in_cnt=7
    do_reset();
    for (int k = 0; k < 23; k++) beat((k % 16) == 15, 1'b0, 1'b1);
    chk("mid_valid_before", int'(o_out_valid), 1);
    i_reset = 1'b1;
    idle(1);
    chk("mid_valid_after", int'(o_out_valid), 0);
    chk("mid_busy_after", int'(o_busy), 0);
    chk("mid_br_reset", n_brst, 1);
    i_reset = 1'b0;
    clr();
    for (int k = 0; k < 16; k++) beat(k == 15, 1'b0, 1'b1);
    chk("mid_refill_no_out", n_valid, 0);
    beat(1'b0, 1'b0, 1'b1);
    chk("mid_refill_out", int'(o_out_valid), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
